// File: rtl/gc_refresh_ctrl_if.sv
// Signal bundle between the refresh controller, its user port and the two gain-cell wrappers.
// The master view is the controller; the slave view is its environment (user side and wrappers).
interface gc_refresh_ctrl_if #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 64
);
   logic              user_req;
   logic              user_we;
   logic [ADDR_W-1:0] user_addr;
   logic [DATA_W-1:0] user_wdata;
   logic              user_ready;
   logic              user_rvalid;
   logic [DATA_W-1:0] user_rdata;
   logic              force_ref;
   logic              u_we_current;
   logic              u_we_old;
   logic              u_re_current;
   logic              u_re_old;
   logic [ADDR_W-1:0] u_write_addr;
   logic [ADDR_W-1:0] u_read_addr;
   logic [DATA_W-1:0] u_data_in;
   logic              ref_en_old;
   logic              ref_en_current;
   logic              start_SR;
   logic              ref_done;
   logic [DATA_W-1:0] rd_current;
   logic [DATA_W-1:0] rd_old;
   logic              bank_sel;
   logic              ref_busy;
   logic              ref_err;

   modport master (
      input  user_req, user_we, user_addr, user_wdata, force_ref, ref_done, rd_current, rd_old,
      output user_ready, user_rvalid, user_rdata, u_we_current, u_we_old, u_re_current,
             u_re_old, u_write_addr, u_read_addr, u_data_in, ref_en_old, ref_en_current,
             start_SR, bank_sel, ref_busy, ref_err
   );

   modport slave (
      output user_req, user_we, user_addr, user_wdata, force_ref, ref_done, rd_current, rd_old,
      input  user_ready, user_rvalid, user_rdata, u_we_current, u_we_old, u_re_current,
             u_re_old, u_write_addr, u_read_addr, u_data_in, ref_en_old, ref_en_current,
             start_SR, bank_sel, ref_busy, ref_err
   );
endinterface

// File: rtl/gc_refresh_ctrl.sv
// Copy-refresh controller for two role-swapping gain-cell banks; arbitrates a user port
// against periodic refresh so that refresh is hidden behind a short drain/start bubble.
module gc_refresh_ctrl #(
   parameter int unsigned ADDR_W     = 7,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned DEPTH      = 128,
   parameter int unsigned REF_PERIOD = 1000,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned TO_MARGIN  = 8
) (
   input logic               clk,
   input logic               rst_n,
   gc_refresh_ctrl_if.master bus
);
   localparam int unsigned TimerW = $clog2(REF_PERIOD + 1);
   localparam int unsigned RowW   = $clog2(DEPTH + TO_MARGIN + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(REF_PERIOD - 1);
   localparam logic [RowW-1:0]   RowLast   = RowW'(DEPTH + TO_MARGIN - 1);

   typedef enum logic [2:0] {StIdle, StDrain, StStart, StRefresh, StDone} state_e;

   state_e            state_q;
   logic [TimerW-1:0] timer_q;
   logic [RowW-1:0]   row_q;
   logic              ready_q;
   logic              start_sr_q;
   logic              bank_sel_q;
   logic              ref_en_q;
   logic              ref_busy_q;
   logic              ref_err_q;

   logic              we_cur_q;
   logic              we_old_q;
   logic              re_cur_q;
   logic              re_old_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [ADDR_W-1:0] raddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [RD_LAT+1:0] rd_vld_q;
   logic [RD_LAT+1:0] rd_tag_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;

   logic              in_ref;
   logic              ready;
   logic              acc_wr;
   logic              acc_rd;
   logic              in_flight;
   logic              expire;
   logic [TimerW-1:0] timer_inc;
   logic [RowW-1:0]   row_inc;

   assign in_ref    = (state_q == StRefresh);
   // force_ref must block the request in the very cycle it is seen, so it bypasses ready_q.
   assign ready     = ready_q & ~((state_q == StIdle) & bus.force_ref);
   assign acc_wr    = bus.user_req & ready & bus.user_we;
   assign acc_rd    = bus.user_req & ready & ~bus.user_we;
   assign in_flight = |rd_vld_q;
   assign expire    = (timer_q == TimerLast) | bus.force_ref;
   assign timer_inc = timer_q + TimerW'(1);
   assign row_inc   = row_q + RowW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         row_q      <= '0;
         ready_q    <= 1'b0;
         start_sr_q <= 1'b0;
         bank_sel_q <= 1'b0;
         ref_en_q   <= 1'b0;
         ref_busy_q <= 1'b0;
         ref_err_q  <= 1'b0;
      end else begin
         start_sr_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (expire) begin
                  state_q <= StDrain;
                  ready_q <= 1'b0;
               end else begin
                  timer_q <= timer_inc;
                  ready_q <= (timer_inc != TimerLast);
               end
            end
            StDrain: begin
               if (!in_flight) begin
                  state_q    <= StStart;
                  start_sr_q <= 1'b1;
                  bank_sel_q <= ~bank_sel_q;
                  ref_en_q   <= 1'b1;
                  ref_busy_q <= 1'b1;
                  row_q      <= '0;
               end
            end
            StStart: begin
               state_q <= StRefresh;
               ready_q <= 1'b1;
            end
            StRefresh: begin
               row_q <= row_inc;
               if (bus.ref_done || (row_q == RowLast)) begin
                  state_q  <= StDone;
                  ready_q  <= 1'b0;
                  ref_en_q <= 1'b0;
                  // Timeout: the new current bank is incomplete, so fall back to the old one.
                  if (!bus.ref_done) begin
                     ref_err_q  <= 1'b1;
                     bank_sel_q <= ~bank_sel_q;
                  end
               end
            end
            StDone: begin
               state_q    <= StIdle;
               timer_q    <= '0;
               ready_q    <= 1'b1;
               ref_busy_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_cur_q <= 1'b0;
         we_old_q <= 1'b0;
         re_cur_q <= 1'b0;
         re_old_q <= 1'b0;
         waddr_q  <= '0;
         raddr_q  <= '0;
         wdata_q  <= '0;
         rd_vld_q <= '0;
         rd_tag_q <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         // During refresh writes hit both roles and reads come from the complete source bank.
         we_cur_q <= acc_wr;
         we_old_q <= acc_wr & in_ref;
         re_cur_q <= acc_rd & ~in_ref;
         re_old_q <= acc_rd & in_ref;
         if (acc_wr) begin
            waddr_q <= bus.user_addr;
            wdata_q <= bus.user_wdata;
         end
         if (acc_rd) begin
            raddr_q <= bus.user_addr;
         end
         rd_vld_q <= {rd_vld_q[RD_LAT:0], acc_rd};
         rd_tag_q <= {rd_tag_q[RD_LAT:0], in_ref};
         rvalid_q <= rd_vld_q[RD_LAT+1];
         if (rd_vld_q[RD_LAT+1]) begin
            rdata_q <= rd_tag_q[RD_LAT+1] ? bus.rd_old : bus.rd_current;
         end
      end
   end

   assign bus.user_ready     = ready;
   assign bus.user_rvalid    = rvalid_q;
   assign bus.user_rdata     = rdata_q;
   assign bus.u_we_current   = we_cur_q;
   assign bus.u_we_old       = we_old_q;
   assign bus.u_re_current   = re_cur_q;
   assign bus.u_re_old       = re_old_q;
   assign bus.u_write_addr   = waddr_q;
   assign bus.u_read_addr    = raddr_q;
   assign bus.u_data_in      = wdata_q;
   assign bus.ref_en_old     = ref_en_q;
   assign bus.ref_en_current = ref_en_q;
   assign bus.start_SR       = start_sr_q;
   assign bus.bank_sel       = bank_sel_q;
   assign bus.ref_busy       = ref_busy_q;
   assign bus.ref_err        = ref_err_q;
endmodule

// File: tb/tb_gc_refresh_ctrl.sv
// Directed bench for gc_refresh_ctrl with a two-bank wrapper model and an in-order read
// scoreboard; inputs change and outputs are sampled on the falling clock edge.
module tb_gc_refresh_ctrl;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned DEPTH  = 128;

   logic clk;
   logic rst_n;

   gc_refresh_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   gc_refresh_ctrl #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .REF_PERIOD(20),
      .RD_LAT    (1),
      .TO_MARGIN (8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Wrapper model: physical bank bank_sel holds the current role; read data two edges after strobe.
   logic [DATA_W-1:0] mem [0:1][0:DEPTH-1];
   logic [DATA_W-1:0] q1_cur, q1_old, q2_cur, q2_old;

   always @(posedge clk) begin
      if (bus.u_we_current) mem[bus.bank_sel][bus.u_write_addr] <= bus.u_data_in;
      if (bus.u_we_old) mem[~bus.bank_sel][bus.u_write_addr] <= bus.u_data_in;
      q1_cur <= mem[bus.bank_sel][bus.u_read_addr];
      q1_old <= mem[~bus.bank_sel][bus.u_read_addr];
      q2_cur <= q1_cur;
      q2_old <= q1_old;
   end

   assign bus.rd_current = q2_cur;
   assign bus.rd_old     = q2_old;

   int n_tests = 0;
   int n_fail  = 0;
   int rv_count = 0;
   logic [63:0] exp_q[$];
   int rd_addr[4] = '{5, 77, 127, 0};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata);
      bus.user_req   = req;
      bus.user_we    = we;
      bus.user_addr  = addr;
      bus.user_wdata = wdata;
   endtask

   // Leaves the caller on the falling edge of the START cycle.
   task automatic force_refresh();
      int n = 0;
      bus.force_ref = 1'b1;
      tick();
      bus.force_ref = 1'b0;
      while (!bus.start_SR && n < 10) begin
         tick();
         n++;
      end
      check_eq("start_seen", bus.start_SR, 1);
   endtask

   // Read-return scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.user_rvalid) begin
            rv_count++;
            if (exp_q.size() == 0) check_eq("rvalid_unexpected", bus.user_rvalid, 0);
            else check_eq("rdata", bus.user_rdata, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      drive(1'b0, 1'b0, '0, '0);
      bus.force_ref = 1'b0;
      bus.ref_done  = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      tick();
      check_eq("rst_user_ready", bus.user_ready, 0);
      check_eq("rst_rvalid", bus.user_rvalid, 0);
      check_eq("rst_bank_sel", bus.bank_sel, 0);
      check_eq("rst_ref_err", bus.ref_err, 0);
      check_eq("rst_ref_busy", bus.ref_busy, 0);
      check_eq("rst_start_sr", bus.start_SR, 0);
      check_eq("rst_ref_en", bus.ref_en_old, 0);
      tick();
      rst_n = 1'b1;

      // Test 1: IDLE write then read on the current role.
      tick();
      check_eq("t1_ready", bus.user_ready, 1);
      drive(1'b1, 1'b1, 7'd10, 64'd9);
      tick();
      check_eq("t1_we_cur", bus.u_we_current, 1);
      check_eq("t1_we_old", bus.u_we_old, 0);
      check_eq("t1_waddr", bus.u_write_addr, 10);
      check_eq("t1_wdata", bus.u_data_in, 9);
      drive(1'b1, 1'b0, 7'd10, '0);
      exp_q.push_back(64'd9);
      tick();
      check_eq("t1_re_cur", bus.u_re_current, 1);
      check_eq("t1_re_old", bus.u_re_old, 0);
      check_eq("t1_we_cur_off", bus.u_we_current, 0);
      check_eq("t1_raddr", bus.u_read_addr, 10);
      drive(1'b0, 1'b0, '0, '0);
      tick();
      tick();
      check_eq("t1_rvalid_early", bus.user_rvalid, 0);
      tick();
      check_eq("t1_rvalid", bus.user_rvalid, 1);
      check_eq("t1_rdata", bus.user_rdata, 9);
      tick();
      check_eq("t1_rvalid_pulse", bus.user_rvalid, 0);

      // Test 2: forced refresh with nothing in flight.
      bus.force_ref = 1'b1;
      #1 check_eq("t2_ready_on_force", bus.user_ready, 0);
      tick();
      bus.force_ref = 1'b0;
      check_eq("t2_drain_start", bus.start_SR, 0);
      check_eq("t2_drain_busy", bus.ref_busy, 0);
      check_eq("t2_drain_ready", bus.user_ready, 0);
      tick();
      check_eq("t2_start_sr", bus.start_SR, 1);
      check_eq("t2_bank_sel", bus.bank_sel, 1);
      check_eq("t2_ref_en_old", bus.ref_en_old, 1);
      check_eq("t2_ref_en_cur", bus.ref_en_current, 1);
      check_eq("t2_busy", bus.ref_busy, 1);
      check_eq("t2_start_ready", bus.user_ready, 0);
      tick();
      check_eq("t2_start_single", bus.start_SR, 0);
      check_eq("t2_refresh_ready", bus.user_ready, 1);

      // Test 3: writes mirror to both roles; reads come from the old role.
      for (int i = 0; i < 128; i++) begin
         drive(1'b1, 1'b1, ADDR_W'(i), DATA_W'(900 + i));
         tick();
         check_eq("t3_we_cur", bus.u_we_current, 1);
         check_eq("t3_we_old", bus.u_we_old, 1);
         check_eq("t3_waddr", bus.u_write_addr, 64'(i));
         check_eq("t3_wdata", bus.u_data_in, 64'(900 + i));
      end
      for (int j = 0; j < 4; j++) begin
         drive(1'b1, 1'b0, ADDR_W'(rd_addr[j]), '0);
         exp_q.push_back(64'(900 + rd_addr[j]));
         tick();
         check_eq("t3_re_old", bus.u_re_old, 1);
         check_eq("t3_re_cur", bus.u_re_current, 0);
         check_eq("t3_raddr", bus.u_read_addr, 64'(rd_addr[j]));
      end
      drive(1'b0, 1'b0, '0, '0);
      bus.ref_done = 1'b1;
      tick();
      bus.ref_done = 1'b0;
      check_eq("t3_done_busy", bus.ref_busy, 1);
      check_eq("t3_done_en_old", bus.ref_en_old, 0);
      check_eq("t3_done_en_cur", bus.ref_en_current, 0);
      check_eq("t3_done_ready", bus.user_ready, 0);
      tick();
      check_eq("t3_idle_busy", bus.ref_busy, 0);
      check_eq("t3_idle_ready", bus.user_ready, 1);
      check_eq("t3_idle_bank", bus.bank_sel, 1);
      check_eq("t3_idle_err", bus.ref_err, 0);

      // Test 4: read accepted just before timer expiry holds DRAIN until it returns.
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 1) bus.ref_done = 1'b1;
         if (k == 2) begin
            bus.ref_done = 1'b0;
            check_eq("t4_done_ignored", bus.ref_busy, 0);
         end
      end
      check_eq("t4_ready_pre", bus.user_ready, 1);
      drive(1'b1, 1'b0, 7'd3, '0);
      exp_q.push_back(64'd903);
      tick();
      check_eq("t4_re_cur", bus.u_re_current, 1);
      drive(1'b1, 1'b0, 7'd4, '0);
      check_eq("t4_ready_expiry", bus.user_ready, 0);
      tick();
      check_eq("t4_not_accepted", bus.u_re_current, 0);
      check_eq("t4_drain1_start", bus.start_SR, 0);
      drive(1'b0, 1'b0, '0, '0);
      tick();
      check_eq("t4_drain2_start", bus.start_SR, 0);
      check_eq("t4_drain2_ready", bus.user_ready, 0);
      tick();
      check_eq("t4_rvalid", bus.user_rvalid, 1);
      check_eq("t4_drain3_start", bus.start_SR, 0);
      tick();
      check_eq("t4_start_sr", bus.start_SR, 1);
      check_eq("t4_bank_sel", bus.bank_sel, 0);

      // Test 5: no ref_done, timeout after 136 REFRESH cycles.
      for (int r = 0; r < 136; r++) begin
         tick();
         if (r == 0) check_eq("t5_row0_bank", bus.bank_sel, 0);
      end
      check_eq("t5_last_err", bus.ref_err, 0);
      check_eq("t5_last_ready", bus.user_ready, 1);
      tick();
      check_eq("t5_err", bus.ref_err, 1);
      check_eq("t5_bank_back", bus.bank_sel, 1);
      check_eq("t5_done_ready", bus.user_ready, 0);
      check_eq("t5_done_busy", bus.ref_busy, 1);
      check_eq("t5_done_en", bus.ref_en_current, 0);
      tick();
      check_eq("t5_idle_ready", bus.user_ready, 1);
      check_eq("t5_idle_busy", bus.ref_busy, 0);
      tick();
      tick();
      tick();
      check_eq("t5_err_sticky", bus.ref_err, 1);

      // Test 6: reset in the middle of a refresh.
      force_refresh();
      check_eq("t6_bank_a", bus.bank_sel, 0);
      tick();
      bus.ref_done = 1'b1;
      tick();
      bus.ref_done = 1'b0;
      check_eq("t6_done_a", bus.ref_busy, 1);
      tick();
      check_eq("t6_idle_a", bus.user_ready, 1);
      force_refresh();
      check_eq("t6_bank_b", bus.bank_sel, 1);
      for (int r = 0; r < 50; r++) tick();
      drive(1'b1, 1'b1, 7'd49, 64'd77);
      tick();
      check_eq("t6_row50_we_old", bus.u_we_old, 1);
      check_eq("t6_row50_busy", bus.ref_busy, 1);
      drive(1'b0, 1'b0, '0, '0);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_bank", bus.bank_sel, 0);
      check_eq("t6_rst_we_old", bus.u_we_old, 0);
      check_eq("t6_rst_we_cur", bus.u_we_current, 0);
      check_eq("t6_rst_waddr", bus.u_write_addr, 0);
      check_eq("t6_rst_busy", bus.ref_busy, 0);
      check_eq("t6_rst_en", bus.ref_en_old, 0);
      check_eq("t6_rst_ready", bus.user_ready, 0);
      check_eq("t6_rst_err", bus.ref_err, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("t6_ready_after", bus.user_ready, 1);
      check_eq("t6_busy_after", bus.ref_busy, 0);
      n = 1;
      while (!bus.start_SR && n < 60) begin
         tick();
         n++;
      end
      check_eq("t6_ref_period", 64'(n), 21);

      check_eq("read_count", 64'(rv_count), 6);
      check_eq("reads_pending", 64'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/gc_refresh_ctrl.md
Name: gc_refresh_ctrl

Overview:
- Controller side of the gain-cell memory wrapper interface: it drives the user access signals and the refresh handshake that the wrapper receives.
- It manages two wrapper instances in a role-swapping copy-refresh scheme. The "current" bank is live. On refresh, the roles swap and the stale bank is streamed from "old" into the new "current" in DEPTH cycles.
- It arbitrates a user valid/ready port against refresh, so refresh is hidden except for a short drain/start bubble.

Parameters:
ADDR_W, 7, row address width
DATA_W, 64, data width
DEPTH, 128, rows per bank (2**ADDR_W)
REF_PERIOD, 1000, idle cycles between refresh starts
RD_LAT, 1, wrapper read latency in cycles (u_re_* to rd_* valid)
TO_MARGIN, 8, extra cycles beyond DEPTH before refresh timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
user_req  in  1  user request valid
user_we  in  1  1=write, 0=read
user_addr  in  ADDR_W  user row address
user_wdata  in  DATA_W  user write data
user_ready  out  1  request accepted when user_req&user_ready at posedge
user_rvalid  out  1  one-cycle read data valid pulse
user_rdata  out  DATA_W  read data
force_ref  in  1  request immediate refresh (level, sampled in IDLE)
u_we_current  out  1  write strobe, current-role bank
u_we_old  out  1  write strobe, old-role bank
u_re_current  out  1  read strobe, current-role bank
u_re_old  out  1  read strobe, old-role bank
u_write_addr  out  ADDR_W  write address (both roles)
u_read_addr  out  ADDR_W  read address
u_data_in  out  DATA_W  write data (both roles)
ref_en_old  out  1  old bank streams refresh data
ref_en_current  out  1  current bank accepts refresh data
start_SR  out  1  one-cycle refresh start pulse
ref_done  in  1  current-bank wrapper reports last row copied
rd_current  in  DATA_W  read data from current-role bank
rd_old  in  DATA_W  read data from old-role bank
bank_sel  out  1  physical bank holding the current role (external role mux)
ref_busy  out  1  high from START through DONE
ref_err  out  1  sticky refresh timeout flag

Behaviour:
- Reset:
  - All outputs are 0. bank_sel=0, ref_err=0.
  - Timer, row counter and read pipeline are cleared. State is IDLE.
  - Reset mid-refresh abandons the refresh with bank_sel=0.
- All memory-side outputs are registered. A request accepted at edge T drives strobes, addresses and data during cycle T+1.
- FSM IDLE / DRAIN / START / REFRESH / DONE:
  - IDLE:
    - user_ready=1. The timer increments each cycle.
    - When the timer reaches REF_PERIOD-1, or force_ref=1, go to DRAIN. The request presented in that same cycle is not accepted (user_ready=0 that cycle).
  - DRAIN:
    - user_ready=0.
    - Wait until no read is in flight (RD_LAT+1 stages), then go to START. If the pipeline is already empty, DRAIN lasts 1 cycle.
  - START (1 cycle):
    - start_SR=1 and bank_sel toggles.
    - ref_en_old=ref_en_current=1 from this cycle onward.
    - Row counter cleared. user_ready=0.
  - REFRESH:
    - user_ready=1. The row counter increments each cycle.
    - Writes assert both u_we_current and u_we_old with the same address and data, so both banks stay coherent and a user write beats refresh data for that row.
    - Reads assert u_re_old only; the source bank is always complete.
    - ref_done=1 → DONE.
    - If the counter reaches DEPTH+TO_MARGIN without ref_done: set ref_err, toggle bank_sel back to its pre-START value, go to DONE.
  - DONE (1 cycle):
    - ref_en_*=0, user_ready=0, timer cleared, then IDLE.
- IDLE accesses use the current role only: u_we_current / u_re_current. u_we_old=u_re_old=0.
- Read return:
  - Each in-flight read carries a role tag.
  - user_rdata is registered from rd_current or rd_old per the tag.
  - user_rvalid pulses exactly RD_LAT+2 cycles after the accepting edge.
  - Reads are in order, one per cycle maximum.
- ref_done outside REFRESH is ignored. start_SR never repeats within one refresh.
- ref_busy=1 in START, REFRESH and DONE.
- ref_err clears only on reset.

Test Plan:
1. Reset, write 9 to addr 10, read addr 10 → u_we_current one cycle then u_re_current; user_rvalid 3 cycles after read accept, user_rdata=9; u_*_old stay 0.
2. force_ref=1 with no reads in flight → DRAIN 1 cycle, start_SR single pulse, bank_sel 0→1, ref_en_old=ref_en_current=1; assert ref_done after 128 cycles → DONE, ref_busy falls, user_ready=1.
3. During refresh, write 900+i to addr i for i=0..127 → u_we_old=u_we_current=1 each write, same addr/data; reads issued during refresh show u_re_old=1 and return mirror model data.
4. Read accepted in the cycle before the timer expires (REF_PERIOD=20) → DRAIN holds until user_rvalid has pulsed, then START; the request presented on the expiry cycle sees user_ready=0.
5. Refresh with ref_done never asserted → after 136 REFRESH cycles ref_err=1, bank_sel returns to its original value, state returns to IDLE, ref_err stays 1.
6. Assert rst_n=0 mid-REFRESH (row 50) → all outputs 0 immediately, bank_sel=0; after release, IDLE with user_ready=1 and the next refresh after REF_PERIOD cycles.
